dspe_dot_sequencer: RTL and testbench

- Initiator that drives one DSPELogic MAC element, which has no flow control of its own.
- Consumes a stream of operand pairs grouped into vectors, and issues a bias beat plus one MAC beat per pair, with hold beats while the input stalls.
- Tags the last beat through the element's extra-signal path and captures the finished accumulator into a small result FIFO with valid/ready output.
- Sits between the weight/activation fetch logic and the result write-back in each KAN compute lane.

---
 rtl/dspe_dot_sequencer_pkg.sv | 27 ++
 rtl/dspe_dot_sequencer_if.sv | 38 +++
 rtl/dspe_result_fifo.sv | 51 +++++
 rtl/dspe_dot_sequencer.sv | 111 +++++++++++
 tb/tb_dspe_dot_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dspe_dot_sequencer_pkg.sv
// Shared types and constants for the DSPELogic dot-product sequencer.
// A beat is the control word presented to the MAC element each cycle.
package dspe_dot_sequencer_pkg;

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  typedef struct packed {
    logic bypass_mlt;
    logic bypass_add;
    logic reset_acc;
    logic extra_in;
  } ctrl_t;

  localparam ctrl_t CTRL_HOLD = '{bypass_mlt: 1'b0, bypass_add: 1'b1, reset_acc: 1'b0, extra_in: 1'b0};
  localparam ctrl_t CTRL_BIAS = '{bypass_mlt: 1'b1, bypass_add: 1'b0, reset_acc: 1'b1, extra_in: 1'b0};
  localparam ctrl_t CTRL_MAC  = '{bypass_mlt: 1'b0, bypass_add: 1'b0, reset_acc: 1'b0, extra_in: 1'b0};

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width able to hold 0..depth inclusive (credit and occupancy counters).
  function automatic int cred_width(input int depth);
    return max_i($clog2(depth + 1), 1);
  endfunction

endpackage

// File: rtl/dspe_dot_sequencer_if.sv
// Bundle of the operand stream, result stream and MAC element control/return.
// master is the sequencer's view; slave is the surrounding lane's view.
interface dspe_dot_sequencer_if #(
  parameter int OP0_SIZE = 8,
  parameter int OP1_SIZE = 8,
  parameter int ACC_SIZE = 24
);
  logic                s_valid;
  logic                s_ready;
  logic [OP0_SIZE-1:0] s_op0;
  logic [OP1_SIZE-1:0] s_op1;
  logic                s_last;
  logic [ACC_SIZE-1:0] s_bias;
  logic                m_valid;
  logic                m_ready;
  logic [ACC_SIZE-1:0] m_acc;
  logic [OP0_SIZE-1:0] dsp_op0;
  logic [OP1_SIZE-1:0] dsp_op1;
  logic [ACC_SIZE-1:0] dsp_op2;
  logic                dsp_bypass_mlt;
  logic                dsp_bypass_add;
  logic                dsp_reset_acc;
  logic                dsp_extra_in;
  logic [ACC_SIZE-1:0] dsp_acc;
  logic                dsp_extra_out;

  modport master (
    input  s_valid, s_op0, s_op1, s_last, s_bias, m_ready, dsp_acc, dsp_extra_out,
    output s_ready, m_valid, m_acc, dsp_op0, dsp_op1, dsp_op2,
           dsp_bypass_mlt, dsp_bypass_add, dsp_reset_acc, dsp_extra_in
  );

  modport slave (
    output s_valid, s_op0, s_op1, s_last, s_bias, m_ready, dsp_acc, dsp_extra_out,
    input  s_ready, m_valid, m_acc, dsp_op0, dsp_op1, dsp_op2,
           dsp_bypass_mlt, dsp_bypass_add, dsp_reset_acc, dsp_extra_in
  );
endinterface

// File: rtl/dspe_result_fifo.sv
// Small synchronous FIFO holding finished accumulator values.
module dspe_result_fifo
  import dspe_dot_sequencer_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = max_i($clog2(DEPTH), 1);
  localparam int CW = cred_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/dspe_dot_sequencer.sv
// Drives one DSPELogic MAC element: a bias beat then one MAC beat per operand pair,
// tags the last beat and captures the returned accumulator into a credited result FIFO.
module dspe_dot_sequencer
  import dspe_dot_sequencer_pkg::*;
#(
  parameter int OP0_SIZE       = 8,
  parameter int OP1_SIZE       = 8,
  parameter int ACC_SIZE       = 24,
  parameter int PIPELINE_LEVEL = 2,
  parameter int RES_DEPTH      = 2
) (
  input logic                  clk,
  input logic                  rst,
  dspe_dot_sequencer_if.master bus
);
  localparam int CW = cred_width(RES_DEPTH);

  state_t              state_q, state_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic [OP0_SIZE-1:0] op0_q, op0_d;
  logic [OP1_SIZE-1:0] op1_q, op1_d;
  logic [ACC_SIZE-1:0] op2_q, op2_d;
  logic [CW-1:0]       credits_q;
  logic                start, pop, cap_q, fifo_full, fifo_empty;
  logic [PIPELINE_LEVEL:0] tag_sr;

  always_comb begin
    state_d = state_q;
    ctrl_d  = CTRL_HOLD;
    op0_d   = '0;
    op1_d   = '0;
    op2_d   = '0;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.s_valid && credits_q != '0) begin
          ctrl_d  = CTRL_BIAS;
          op2_d   = bus.s_bias;
          start   = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.s_valid) begin
          ctrl_d          = CTRL_MAC;
          ctrl_d.extra_in = bus.s_last;
          op0_d           = bus.s_op0;
          op1_d           = bus.s_op1;
          if (bus.s_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.s_ready = (state_q == ACCUM);
  assign pop         = bus.m_ready && !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ctrl_q    <= CTRL_HOLD;
      op0_q     <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      credits_q <= CW'(RES_DEPTH);
      cap_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      op0_q   <= op0_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      cap_q   <= bus.dsp_extra_out;
      if (start && !pop)      credits_q <= credits_q - CW'(1);
      else if (pop && !start) credits_q <= credits_q + CW'(1);
    end
  end

  // Shadow of the tag: the element must return it exactly PIPELINE_LEVEL+1 cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_sr <= '0;
    end else begin
      assert (bus.dsp_extra_out == tag_sr[PIPELINE_LEVEL]);
      assert (!(cap_q && fifo_full));
      tag_sr[0] <= ctrl_q.extra_in;
      for (int i = 1; i <= PIPELINE_LEVEL; i++) tag_sr[i] <= tag_sr[i-1];
    end
  end

  assign bus.dsp_op0        = op0_q;
  assign bus.dsp_op1        = op1_q;
  assign bus.dsp_op2        = op2_q;
  assign bus.dsp_bypass_mlt = ctrl_q.bypass_mlt;
  assign bus.dsp_bypass_add = ctrl_q.bypass_add;
  assign bus.dsp_reset_acc  = ctrl_q.reset_acc;
  assign bus.dsp_extra_in   = ctrl_q.extra_in;
  assign bus.m_valid        = !fifo_empty;

  dspe_result_fifo #(.WIDTH(ACC_SIZE), .DEPTH(RES_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cap_q),
    .din   (bus.dsp_acc),
    .pop   (pop),
    .dout  (bus.m_acc),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_dspe_dot_sequencer.sv
// Scoreboard bench for dspe_dot_sequencer with a behavioural DSPELogic MAC element model.
module tb_dspe_dot_sequencer;
  localparam int OP0_SIZE  = 8;
  localparam int OP1_SIZE  = 8;
  localparam int ACC_SIZE  = 24;
  localparam int PL        = 2;
  localparam int RES_DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dspe_dot_sequencer_if #(.OP0_SIZE(OP0_SIZE), .OP1_SIZE(OP1_SIZE), .ACC_SIZE(ACC_SIZE)) bus();

  dspe_dot_sequencer #(
    .OP0_SIZE(OP0_SIZE), .OP1_SIZE(OP1_SIZE), .ACC_SIZE(ACC_SIZE),
    .PIPELINE_LEVEL(PL), .RES_DEPTH(RES_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // MAC element: PL+1 input stages, then the accumulator; the tag leaves the last stage.
  typedef struct packed {
    logic [OP0_SIZE-1:0] a;
    logic [OP1_SIZE-1:0] b;
    logic [ACC_SIZE-1:0] c;
    logic bm, ba, ra, tag;
  } mbeat_t;
  localparam mbeat_t MB_HOLD = '{a: '0, b: '0, c: '0, bm: 1'b0, ba: 1'b1, ra: 1'b0, tag: 1'b0};

  mbeat_t pipe [PL+1];
  logic [ACC_SIZE-1:0] macc;
  logic signed [OP0_SIZE+OP1_SIZE-1:0] prod;
  logic signed [ACC_SIZE-1:0] prod_x;
  assign prod   = $signed(pipe[PL].a) * $signed(pipe[PL].b);
  assign prod_x = ACC_SIZE'(prod);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= PL; i++) pipe[i] <= MB_HOLD;
      macc <= '0;
    end else begin
      pipe[0] <= '{a: bus.dsp_op0, b: bus.dsp_op1, c: bus.dsp_op2, bm: bus.dsp_bypass_mlt,
                   ba: bus.dsp_bypass_add, ra: bus.dsp_reset_acc, tag: bus.dsp_extra_in};
      for (int i = 1; i <= PL; i++) pipe[i] <= pipe[i-1];
      if (!pipe[PL].ba) macc <= pipe[PL].ra ? pipe[PL].c : macc + prod_x;
    end
  end
  assign bus.dsp_acc       = macc;
  assign bus.dsp_extra_out = pipe[PL].tag;

  typedef struct {
    longint acc;
    bit     lat;
    int     hs;
  } exp_t;
  exp_t q[$];
  int   ops[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   last_hs = 0;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint act, input longint want);
    checks++;
    if (act == want) passes++;
    else $display("FAIL %s: got %0d, want %0d", name, act, want);
  endfunction

  // Monitor: pops the scoreboard whenever a result is accepted.
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else if (bus.m_valid) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_result: got m_acc=%0d, want no result", $signed(bus.m_acc));
      end else begin
        if (!seen) begin
          seen = 1'b1;
          if (q[0].lat) chk("result_latency", longint'(cyc - q[0].hs), PL + 3);
        end
        if (bus.m_ready) begin
          chk("m_acc", longint'($signed(bus.m_acc)), q[0].acc);
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic put_pair(input int a, input int b, input bit last, input longint bias);
    int  n = 0;
    bit  hs = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_op0   = OP0_SIZE'(a);
    bus.s_op1   = OP1_SIZE'(b);
    bus.s_last  = last;
    bus.s_bias  = ACC_SIZE'(bias);
    do begin
      @(negedge clk);
      hs = bus.s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 60);
    if (!hs) begin
      checks++;
      $display("FAIL handshake_timeout: got no s_ready in %0d cycles, want handshake", n);
    end
    last_hs     = cyc;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic run_vec(input longint bias, input longint want, input bit lat, input int gap_at);
    int   n = ops.size() / 2;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      put_pair(ops[2*i], ops[2*i+1], i == n - 1, bias);
      if (i == gap_at) begin
        for (int g = 0; g < 3; g++) begin
          @(posedge clk);
          #1;
          chk("gap_hold_beat", {bus.dsp_bypass_add, bus.dsp_reset_acc, bus.dsp_extra_in}, 3'b100);
        end
      end
    end
    e.acc = want;
    e.lat = lat;
    e.hs  = last_hs;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d results outstanding, want 0", q.size());
      q.delete();
    end
    #1;
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_op0   = '0;
    bus.s_op1   = '0;
    bus.s_last  = 1'b0;
    bus.s_bias  = '0;
    bus.m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_m_valid", bus.m_valid, 0);
    chk("reset_s_ready", bus.s_ready, 0);
    chk("reset_ctrl", {bus.dsp_bypass_mlt, bus.dsp_bypass_add, bus.dsp_reset_acc, bus.dsp_extra_in}, 4'b0100);
    chk("reset_op2", bus.dsp_op2, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 5 + 6 - 8 + 1, with latency check
    ops = {2, 3, -4, 2, 1, 1};
    run_vec(5, 4, 1'b1, -1);
    drain();

    // -1 + 16384 + 16384
    ops = {-128, -128, -128, -128};
    run_vec(-1, 32767, 1'b0, -1);
    drain();

    // same vector with a 3-cycle input gap after the first pair
    ops = {2, 3, -4, 2, 1, 1};
    run_vec(5, 4, 1'b0, 0);
    drain();

    // back-to-back single-pair vectors, including a wrapping one
    ops = {3, 4};     run_vec(0, 12, 1'b0, -1);
    ops = {-2, 7};    run_vec(1, -13, 1'b0, -1);
    ops = {127, 127}; run_vec(-50, 16079, 1'b0, -1);
    ops = {1, 1};     run_vec(8388607, -8388608, 1'b0, -1);
    drain();

    // backpressure: two results fill the credits, third vector must wait
    bus.m_ready = 1'b0;
    ops = {1, 2}; run_vec(10, 12, 1'b0, -1);
    ops = {4, 4}; run_vec(-3, 13, 1'b0, -1);
    bus.s_valid = 1'b1;
    bus.s_op0   = OP0_SIZE'(-1);
    bus.s_op1   = OP1_SIZE'(5);
    bus.s_last  = 1'b1;
    bus.s_bias  = ACC_SIZE'(100);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("blocked_s_ready", bus.s_ready, 0);
      chk("blocked_no_bias", bus.dsp_reset_acc, 0);
    end
    chk("blocked_m_valid", bus.m_valid, 1);
    bus.m_ready = 1'b1;
    ops = {-1, 5}; run_vec(100, 95, 1'b0, -1);
    drain();

    // reset mid-vector with a result parked in the FIFO
    bus.m_ready = 1'b0;
    ops = {2, 2}; run_vec(2, 6, 1'b0, -1);
    repeat (8) @(posedge clk);
    #1;
    bus.s_valid = 1'b1;
    bus.s_op0   = OP0_SIZE'(5);
    bus.s_op1   = OP1_SIZE'(5);
    bus.s_last  = 1'b0;
    bus.s_bias  = ACC_SIZE'(7);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midreset_m_valid", bus.m_valid, 0);
    chk("midreset_s_ready", bus.s_ready, 0);
    chk("midreset_ctrl", {bus.dsp_bypass_mlt, bus.dsp_bypass_add, bus.dsp_reset_acc, bus.dsp_extra_in}, 4'b0100);
    q.delete();
    bus.s_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // both credits must be back: two vectors start with no pops
    ops = {3, 3}; run_vec(0, 9, 1'b0, -1);
    ops = {1, 1}; run_vec(0, 1, 1'b0, -1);
    bus.m_ready = 1'b1;
    drain();
    repeat (10) @(posedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
